// File: rtl/decode_pipe_if.sv
// -----------------------------------------------------------------------------
// decode_pipe_if
//   Bundles every handshake / data signal of the decode stage so fetch,
//   execute and writeback connect to decode_pipe through one port.
//
//   Fetch side     : in_valid, in_ready, in_instr, in_pc
//   Execute side   : out_valid, out_ready, out_rs_data, out_rt_data, out_imm,
//                    out_rd, out_reg_wrt, out_mem_wrt, out_mem_rd, out_halt,
//                    out_opcode, out_pc
//   Writeback side : wb_en, wb_reg, wb_data
//   Control        : flush (squash ID/EX bundle), stall (hazard indicator)
//   Optional       : stall_cycles, issue_count (only when DECODE_PERF_CNT_EN
//                    is defined)
//
//   Modports: slave  - the decode stage itself
//             master - the surrounding pipeline (fetch/execute/writeback)
// -----------------------------------------------------------------------------
interface decode_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_AW     = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [15:0]           in_instr;
    logic [DATA_WIDTH-1:0] in_pc;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_rs_data;
    logic [DATA_WIDTH-1:0] out_rt_data;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [REG_AW-1:0]     out_rd;
    logic                  out_reg_wrt;
    logic                  out_mem_wrt;
    logic                  out_mem_rd;
    logic                  out_halt;
    logic [4:0]            out_opcode;
    logic [DATA_WIDTH-1:0] out_pc;

    logic                  wb_en;
    logic [REG_AW-1:0]     wb_reg;
    logic [DATA_WIDTH-1:0] wb_data;

    logic                  flush;
    logic                  stall;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0]           stall_cycles;
    logic [31:0]           issue_count;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_en, wb_reg, wb_data, flush,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_rd,
               out_reg_wrt, out_mem_wrt, out_mem_rd, out_halt, out_opcode, out_pc,
               stall, stall_cycles, issue_count
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_en, wb_reg, wb_data, flush,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_rd,
               out_reg_wrt, out_mem_wrt, out_mem_rd, out_halt, out_opcode, out_pc,
               stall, stall_cycles, issue_count
    );
`else
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_en, wb_reg, wb_data, flush,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_rd,
               out_reg_wrt, out_mem_wrt, out_mem_rd, out_halt, out_opcode, out_pc,
               stall
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_en, wb_reg, wb_data, flush,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_imm, out_rd,
               out_reg_wrt, out_mem_wrt, out_mem_rd, out_halt, out_opcode, out_pc,
               stall
    );
`endif

endinterface

// File: rtl/decode_pipe.sv
// -----------------------------------------------------------------------------
// decode_pipe
//   Pipelined instruction decode stage. Accepts one 16-bit instruction per
//   cycle from fetch (valid/ready), decodes control and immediate, reads a
//   NUM_REGS x DATA_WIDTH register file (writeback bypassed into the read),
//   tracks in-flight destination registers in a pending-write scoreboard to
//   block RAW/WAW hazards, and registers the result into the ID/EX bundle.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-low reset
//     bus  - decode_pipe_if.slave: fetch handshake, ID/EX bundle with
//            valid/ready, writeback write port, flush input, stall output
//
//   Optional feature (macro DECODE_PERF_CNT_EN):
//     adds saturating 32-bit counters bus.stall_cycles (cycles with stall
//     high) and bus.issue_count (accepted instructions).
//
//   Instruction fields: opcode [15:11], Rs [10:8], Rt [7:5], Rd(R-type) [4:2].
// -----------------------------------------------------------------------------
module decode_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_AW     = 3,
    parameter int LINK_REG   = 7
) (
    input  logic         clk,
    input  logic         rst,
    decode_pipe_if.slave bus
);

    localparam int NUM_REGS = 2 ** REG_AW;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [REG_AW-1:0]     reg_t;

    typedef struct packed {
        logic       reg_wrt;
        logic       mem_wrt;
        logic       mem_rd;
        logic       halt;
        reg_t       rd;
        data_t      imm;
        logic [4:0] opcode;
    } ctrl_t;

    // -------------------------------------------------------------------------
    // Instruction decode (pure function of the instruction word)
    // -------------------------------------------------------------------------
    function automatic ctrl_t decode(input logic [15:0] instr);
        ctrl_t      c;
        logic [4:0] op;
        op       = instr[15:11];
        c        = '0;
        c.opcode = op;

        // Only jumps without link, branches, halt/nop and plain store skip
        // the register write; JAL/JALR write the link register.
        casez (op)
            5'b000??, 5'b0010?, 5'b011??, 5'b10000: c.reg_wrt = 1'b0;
            default:                                c.reg_wrt = 1'b1;
        endcase

        c.mem_wrt = (op == 5'b10000) || (op == 5'b10011);
        c.mem_rd  = (op == 5'b10001);
        c.halt    = (op == 5'b00000);

        casez (op)
            5'b0011?:                     c.rd = reg_t'(LINK_REG);
            5'b11011, 5'b11010, 5'b111??: c.rd = reg_t'(instr[4:2]);
            5'b11000, 5'b10010, 5'b10011: c.rd = reg_t'(instr[10:8]);
            default:                      c.rd = reg_t'(instr[7:5]);
        endcase

        // Immediate width by format: 11-bit jump displacement, 8-bit
        // branch/jump-register/load-immediate, else 5-bit I-type. SLBI and the
        // logical immediates are the only zero-extended forms.
        casez (op)
            5'b00100, 5'b00110:
                c.imm = {{(DATA_WIDTH-11){instr[10]}}, instr[10:0]};
            5'b10010:
                c.imm = {{(DATA_WIDTH-8){1'b0}}, instr[7:0]};
            5'b001?1, 5'b011??, 5'b11000:
                c.imm = {{(DATA_WIDTH-8){instr[7]}}, instr[7:0]};
            5'b0101?:
                c.imm = {{(DATA_WIDTH-5){1'b0}}, instr[4:0]};
            default:
                c.imm = {{(DATA_WIDTH-5){instr[4]}}, instr[4:0]};
        endcase
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    ctrl_t               dec;
    reg_t                rs_addr;
    reg_t                rt_addr;
    data_t               rs_data;
    data_t               rt_data;
    data_t               rf [NUM_REGS];

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_eff;
    logic [NUM_REGS-1:0] pend_next;
    logic [NUM_REGS-1:0] wb_mask;

    logic                hazard;
    logic                in_ready;
    logic                load;

    logic                out_valid_q;
    ctrl_t               out_ctrl_q;
    data_t               out_rs_q;
    data_t               out_rt_q;
    data_t               out_pc_q;

    // -------------------------------------------------------------------------
    // Combinational decode, operand read and hazard detection
    // -------------------------------------------------------------------------
    assign dec     = decode(bus.in_instr);
    assign rs_addr = reg_t'(bus.in_instr[10:8]);
    assign rt_addr = reg_t'(bus.in_instr[7:5]);

    // Same-cycle writeback is forwarded so an instruction released by that
    // writeback captures the new value rather than the stale array entry.
    assign rs_data = (bus.wb_en && (bus.wb_reg == rs_addr)) ? bus.wb_data : rf[rs_addr];
    assign rt_data = (bus.wb_en && (bus.wb_reg == rt_addr)) ? bus.wb_data : rf[rt_addr];

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wb_mask = '0;
        if (bus.wb_en) begin
            wb_mask[bus.wb_reg] = 1'b1;
        end
    end

    // The hazard check sees the scoreboard after this cycle's writeback, so
    // the writeback that completes a pending register releases the stall now.
    assign pend_eff = pend & ~wb_mask;

    assign hazard = bus.in_valid &
                    (pend_eff[rs_addr] | pend_eff[rt_addr] |
                     (dec.reg_wrt & pend_eff[dec.rd]));

    assign in_ready = ~hazard & (~out_valid_q | bus.out_ready) & ~bus.flush;
    assign load     = bus.in_valid & in_ready;

    // Scoreboard next state: writeback and flush clear, a new issue sets.
    // The set is applied last so a same-cycle set and clear leaves it set.
    always_comb begin
        pend_next = pend_eff;
        if (bus.flush && out_valid_q && out_ctrl_q.reg_wrt) begin
            pend_next[out_ctrl_q.rd] = 1'b0;
        end
        if (load && dec.reg_wrt) begin
            pend_next[dec.rd] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    // NOTE: the register file is reset like ordinary flops because every
    // architectural register must read 0 after reset; this makes it a flop
    // array rather than an inferred RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.wb_en) begin
            rf[bus.wb_reg] <= bus.wb_data;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // -------------------------------------------------------------------------
    // ID/EX pipeline register
    // -------------------------------------------------------------------------
    // Flush wins over everything (no load can coincide with it); otherwise a
    // load overwrites the bundle, a consumed bundle with no replacement drops
    // valid, and a stalled bundle holds every field.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            out_rs_q    <= '0;
            out_rt_q    <= '0;
            out_pc_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_ctrl_q  <= dec;
            out_rs_q    <= rs_data;
            out_rt_q    <= rt_data;
            out_pc_q    <= bus.in_pc;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.stall       = hazard;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rs_data = out_rs_q;
    assign bus.out_rt_data = out_rt_q;
    assign bus.out_imm     = out_ctrl_q.imm;
    assign bus.out_rd      = out_ctrl_q.rd;
    assign bus.out_reg_wrt = out_ctrl_q.reg_wrt;
    assign bus.out_mem_wrt = out_ctrl_q.mem_wrt;
    assign bus.out_mem_rd  = out_ctrl_q.mem_rd;
    assign bus.out_halt    = out_ctrl_q.halt;
    assign bus.out_opcode  = out_ctrl_q.opcode;
    assign bus.out_pc      = out_pc_q;

`ifdef DECODE_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Saturating performance counters
    // -------------------------------------------------------------------------
    logic [31:0] stall_cycles_q;
    logic [31:0] issue_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            issue_count_q  <= '0;
        end else begin
            if (hazard && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (load && (issue_count_q != 32'hFFFF_FFFF)) begin
                issue_count_q <= issue_count_q + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.issue_count  = issue_count_q;
`endif

endmodule
